// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared headings, cell-state encoding and wall-index helpers
//                for maze movers.
//  Revision    : 1.0  initial release
// ============================================================================
package maze_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    // Position-derived state: no flops hold it, it is decoded from pixel bits.
    typedef enum logic [0:0] {
        MID_CELL = 1'b0,
        AT_CELL  = 1'b1
    } cell_state_t;

    // Opposite heading: right<->left, down<->up.
    function automatic logic [1:0] reverse(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

    // Bit index of the wall on the top edge of cell (c,r).
    function automatic int h_idx(input int c, input int r, input int w);
        return r * w + c;
    endfunction

    // Bit index of the wall on the left edge of cell (c,r).
    function automatic int v_idx(input int c, input int r, input int w);
        return r * (w + 1) + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : grid_mover_if
//  Description : Buttons, step strobe, wall maps and motion outputs of the
//                grid mover.
//  Revision    : 1.0  initial release
// ============================================================================
interface grid_mover_if #(
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 15,
    parameter int CELL_LOG2 = 5
);
    localparam int PX_W = $clog2(GRID_W) + CELL_LOG2;
    localparam int PY_W = $clog2(GRID_H) + CELL_LOG2;

    logic [3:0]                       btn;
    logic                             step;
    logic [GRID_W*(GRID_H+1)-1:0]     h_walls;
    logic [(GRID_W+1)*GRID_H-1:0]     v_walls;
    logic [PX_W-1:0]                  pos_x;
    logic [PY_W-1:0]                  pos_y;
    logic [1:0]                       dir;
    logic                             pend_valid;
    logic                             blocked;
    logic                             moved;
    logic                             cell_enter;

    modport master (
        output btn, step, h_walls, v_walls,
        input  pos_x, pos_y, dir, pend_valid, blocked, moved, cell_enter
    );

    modport slave (
        input  btn, step, h_walls, v_walls,
        output pos_x, pos_y, dir, pend_valid, blocked, moved, cell_enter
    );

endinterface
`default_nettype wire

// File: rtl/maze_wall_probe.sv
`default_nettype none
// ============================================================================
//  Module      : maze_wall_probe
//  Description : Combinational lookup of which of the four headings leave a
//                cell without crossing a wall or the grid edge.
//  Revision    : 1.0  initial release
// ============================================================================
module maze_wall_probe
    import maze_pkg::*;
#(
    parameter int GRID_W = 10,
    parameter int GRID_H = 15,
    parameter int COL_W  = 4,
    parameter int ROW_W  = 4
)(
    input  logic [COL_W-1:0]                 col,
    input  logic [ROW_W-1:0]                 row,
    input  logic [GRID_W*(GRID_H+1)-1:0]     h_walls,
    input  logic [(GRID_W+1)*GRID_H-1:0]     v_walls,
    output logic [3:0]                       open
);
    localparam int HI_W = $clog2(GRID_W * (GRID_H + 1));
    localparam int VI_W = $clog2((GRID_W + 1) * GRID_H);

    int              w_c;
    int              w_r;
    logic [VI_W-1:0] w_idx_right;
    logic [HI_W-1:0] w_idx_down;
    logic [VI_W-1:0] w_idx_left;
    logic [HI_W-1:0] w_idx_up;

    // Wall bit positions surrounding the probed cell, then edge-qualified openings.
    always_comb begin
        w_c         = int'(col);
        w_r         = int'(row);
        w_idx_right = VI_W'(v_idx(w_c + 1, w_r, GRID_W));
        w_idx_down  = HI_W'(h_idx(w_c, w_r + 1, GRID_W));
        w_idx_left  = VI_W'(v_idx(w_c, w_r, GRID_W));
        w_idx_up    = HI_W'(h_idx(w_c, w_r, GRID_W));
        open[DIR_RIGHT] = ~v_walls[w_idx_right] && (w_c < GRID_W - 1);
        open[DIR_DOWN]  = ~h_walls[w_idx_down]  && (w_r < GRID_H - 1);
        open[DIR_LEFT]  = ~v_walls[w_idx_left]  && (w_c > 0);
        open[DIR_UP]    = ~h_walls[w_idx_up]    && (w_r > 0);
    end

endmodule
`default_nettype wire

// File: rtl/grid_mover.sv
`default_nettype none
// ============================================================================
//  Module      : grid_mover
//  Description : Player motion engine: decodes buttons, buffers one turn and
//                advances a pixel position one step at a time through a
//                walled cell grid.
//  Revision    : 1.0  initial release
// ============================================================================
module grid_mover
    import maze_pkg::*;
#(
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 15,
    parameter int CELL_LOG2 = 5,
    parameter int START_COL = 0,
    parameter int START_ROW = 0,
    parameter int START_DIR = 2
)(
    input  logic        clk,
    input  logic        rst,
    grid_mover_if.slave bus
);
    localparam int COL_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int PX_W  = COL_W + CELL_LOG2;
    localparam int PY_W  = ROW_W + CELL_LOG2;

    localparam logic [PX_W-1:0] RST_X   = PX_W'(START_COL << CELL_LOG2);
    localparam logic [PY_W-1:0] RST_Y   = PY_W'(START_ROW << CELL_LOG2);
    localparam logic [1:0]      RST_DIR = 2'(START_DIR);

    logic [PX_W-1:0]  r_pos_x;
    logic [PY_W-1:0]  r_pos_y;
    logic [1:0]       r_dir;
    logic [1:0]       r_pend_dir;
    logic             r_pend_valid;
    logic             r_blocked;
    logic             r_moved;
    logic             r_cell_enter;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [3:0]       w_open;
    cell_state_t      w_state;
    logic             w_req_valid;
    logic [1:0]       w_req_dir;
    logic [1:0]       w_buf_dir;
    logic [1:0]       w_buf_pend_dir;
    logic             w_buf_pend_valid;
    logic [1:0]       w_cand;
    logic             w_cand_buf;
    logic             w_do_move;
    logic [1:0]       w_move_dir;
    logic [PX_W-1:0]  w_pos_x_nxt;
    logic [PY_W-1:0]  w_pos_y_nxt;
    logic [1:0]       w_dir_nxt;
    logic [1:0]       w_pend_dir_nxt;
    logic             w_pend_valid_nxt;
    logic             w_blocked_nxt;
    logic             w_enter_nxt;

    assign w_col = r_pos_x[PX_W-1:CELL_LOG2];
    assign w_row = r_pos_y[PY_W-1:CELL_LOG2];

    maze_wall_probe #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_probe (
        .col     (w_col),
        .row     (w_row),
        .h_walls (bus.h_walls),
        .v_walls (bus.v_walls),
        .open    (w_open)
    );

    // Button decode: lowest set bit has priority.
    always_comb begin
        w_req_valid = 1'b1;
        w_req_dir   = DIR_RIGHT;
        if (bus.btn[0])      w_req_dir = DIR_RIGHT;
        else if (bus.btn[1]) w_req_dir = DIR_DOWN;
        else if (bus.btn[2]) w_req_dir = DIR_LEFT;
        else if (bus.btn[3]) w_req_dir = DIR_UP;
        else                 w_req_valid = 1'b0;
    end

    // Turn/move decisions; the cell state is decoded from the position itself.
    always_comb begin
        w_state = ((r_pos_x[CELL_LOG2-1:0] == '0) && (r_pos_y[CELL_LOG2-1:0] == '0))
                  ? AT_CELL : MID_CELL;

        // Request buffering outside an aligned step: reversals act at once,
        // other turns wait in the single-entry buffer.
        w_buf_dir        = r_dir;
        w_buf_pend_dir   = r_pend_dir;
        w_buf_pend_valid = r_pend_valid;
        if (w_req_valid) begin
            if (w_req_dir == reverse(r_dir)) begin
                w_buf_dir        = w_req_dir;
                w_buf_pend_valid = 1'b0;
            end else if (w_req_dir == r_dir) begin
                w_buf_pend_valid = 1'b0;
            end else begin
                w_buf_pend_dir   = w_req_dir;
                w_buf_pend_valid = 1'b1;
            end
        end

        w_dir_nxt        = w_buf_dir;
        w_pend_dir_nxt   = w_buf_pend_dir;
        w_pend_valid_nxt = w_buf_pend_valid;
        w_blocked_nxt    = r_blocked;
        w_do_move        = 1'b0;
        w_move_dir       = w_buf_dir;
        w_cand           = r_dir;
        w_cand_buf       = 1'b0;

        case (w_state)
            MID_CELL: begin
                // Mid-cell steps follow the (possibly just reversed) heading.
                if (bus.step) begin
                    w_do_move     = 1'b1;
                    w_blocked_nxt = 1'b0;
                end
            end
            AT_CELL: begin
                if (bus.step) begin
                    w_dir_nxt      = r_dir;
                    w_pend_dir_nxt = r_pend_dir;
                    if (w_req_valid) begin
                        w_cand = w_req_dir;
                    end else if (r_pend_valid) begin
                        w_cand     = r_pend_dir;
                        w_cand_buf = 1'b1;
                    end
                    if (w_open[w_cand]) begin
                        w_dir_nxt        = w_cand;
                        w_pend_valid_nxt = 1'b0;
                        w_do_move        = 1'b1;
                        w_move_dir       = w_cand;
                        w_blocked_nxt    = 1'b0;
                    end else if ((w_cand != r_dir) && w_open[r_dir]) begin
                        w_pend_valid_nxt = w_cand_buf;
                        w_do_move        = 1'b1;
                        w_move_dir       = r_dir;
                        w_blocked_nxt    = 1'b0;
                    end else begin
                        w_pend_valid_nxt = w_cand_buf;
                        w_blocked_nxt    = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        w_pos_x_nxt = r_pos_x;
        w_pos_y_nxt = r_pos_y;
        if (w_do_move) begin
            case (w_move_dir)
                DIR_RIGHT: w_pos_x_nxt = r_pos_x + PX_W'(1);
                DIR_DOWN:  w_pos_y_nxt = r_pos_y + PY_W'(1);
                DIR_LEFT:  w_pos_x_nxt = r_pos_x - PX_W'(1);
                default:   w_pos_y_nxt = r_pos_y - PY_W'(1);
            endcase
        end
        w_enter_nxt = w_do_move && (w_pos_x_nxt[CELL_LOG2-1:0] == '0)
                                && (w_pos_y_nxt[CELL_LOG2-1:0] == '0);
    end

    // State register for position, heading, turn buffer and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos_x      <= RST_X;
            r_pos_y      <= RST_Y;
            r_dir        <= RST_DIR;
            r_pend_dir   <= RST_DIR;
            r_pend_valid <= 1'b0;
            r_blocked    <= 1'b0;
            r_moved      <= 1'b0;
            r_cell_enter <= 1'b0;
        end else begin
            r_pos_x      <= w_pos_x_nxt;
            r_pos_y      <= w_pos_y_nxt;
            r_dir        <= w_dir_nxt;
            r_pend_dir   <= w_pend_dir_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_blocked    <= w_blocked_nxt;
            r_moved      <= w_do_move;
            r_cell_enter <= w_enter_nxt;
        end
    end

    assign bus.pos_x      = r_pos_x;
    assign bus.pos_y      = r_pos_y;
    assign bus.dir        = r_dir;
    assign bus.pend_valid = r_pend_valid;
    assign bus.blocked    = r_blocked;
    assign bus.moved      = r_moved;
    assign bus.cell_enter = r_cell_enter;

endmodule
`default_nettype wire
